// File: rtl/instr_stream_encoder.sv
// Packs symbolic instruction records into 16-bit WISC words and writes them sequentially to instruction memory.
// Latency: a record accepted at edge N appears on the write port (mem_wr_en=1) from cycle N+1.
// Backpressure: mem_ready=0 holds the write stable; in_ready drops when the word buffer is full (no pop), after HLT, or outside LOAD.
module instr_stream_encoder #(
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [3:0]        in_a,
   input  logic [3:0]        in_b,
   input  logic [3:0]        in_c,
   input  logic [8:0]        in_imm,
   input  logic [2:0]        in_cond,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] word_count
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_DONE = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);
   // Last even address before the byte address wraps.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ~ADDR_ONE;

   state_t            state_q, state_d;
   logic              hlt_acc_q, hlt_acc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [15:0]       buf_q [FIFO_DEPTH];
   logic [15:0]       buf_d [FIFO_DEPTH];

   logic [15:0]       enc_word;
   logic [15:0]       head_word;
   logic              in_load;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              head_is_hlt;

   // Field packing per opcode class; fields an opcode does not use are dropped.
   always_comb begin
      enc_word = 16'h0000;
      case (in_op)
         4'hA, 4'hB: enc_word = {in_op, in_a, in_imm[7:0]};
         4'hC:       enc_word = {in_op, in_cond, in_imm};
         4'hD:       enc_word = {in_op, in_cond, 1'b0, in_b, 4'h0};
         4'hE:       enc_word = {in_op, in_a, 8'h00};
         4'hF:       enc_word = 16'hF000;
         default:    enc_word = {in_op, in_a, in_b, in_c};
      endcase
   end

   assign in_load     = (state_q == ST_LOAD);
   assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
   assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head_word   = buf_q[rd_ptr_q[PTR_W-1:0]];
   // Only HLT encodes with a top nibble of F.
   assign head_is_hlt = (head_word[15:12] == 4'hF);

   assign mem_wr_en   = in_load && !fifo_empty;
   // Gate the head so the port reads zero whenever no write is offered.
   assign mem_wdata   = mem_wr_en ? head_word : 16'h0000;
   assign mem_addr    = addr_q;
   assign word_count  = cnt_q;
   assign done        = (state_q == ST_DONE);
   assign err         = (state_q == ST_ERR);

   assign pop         = mem_wr_en && mem_ready;
   // A pop in the same cycle frees a slot, so a full buffer still streams.
   assign in_ready    = in_load && !hlt_acc_q && (!fifo_full || pop);
   assign push        = in_valid && in_ready;

   // Next-state: buffer push/pop, address and count advance, LOAD/DONE/ERR transitions.
   always_comb begin
      state_d   = state_q;
      hlt_acc_d = hlt_acc_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      buf_d     = buf_q;

      if (push) begin
         buf_d[wr_ptr_q[PTR_W-1:0]] = enc_word;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (in_op == 4'hF) begin
            hlt_acc_d = 1'b1;
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         addr_d   = addr_q + ADDR_TWO;
         cnt_d    = cnt_q + ADDR_ONE;
      end

      case (state_q)
         ST_LOAD: begin
            if (pop) begin
               if (head_is_hlt) begin
                  state_d = ST_DONE;
               end else if (addr_q == LAST_ADDR) begin
                  // Nothing queued behind the last addressable word may be written.
                  state_d  = ST_ERR;
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
               end
            end
         end
         ST_DONE, ST_ERR: begin
            if (start) begin
               state_d   = ST_LOAD;
               hlt_acc_d = 1'b0;
               addr_d    = BASE_ADDR;
               cnt_d     = '0;
               wr_ptr_d  = '0;
               rd_ptr_d  = '0;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_LOAD;
         hlt_acc_q <= 1'b0;
         addr_q    <= BASE_ADDR;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         buf_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         hlt_acc_q <= hlt_acc_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         buf_q     <= buf_d;
      end
   end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: scoreboard of expected (address, word) pairs filled on accept, drained on writes.
// Latency: writes are compared on the negedge before the completing edge.
// Backpressure: exercised by holding mem_ready low and by a full-buffer streaming phase.
module tb_instr_stream_encoder;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [3:0]  in_a;
   logic [3:0]  in_b;
   logic [3:0]  in_c;
   logic [8:0]  in_imm;
   logic [2:0]  in_cond;
   logic        mem_wr_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic        done;
   logic        err;
   logic [15:0] word_count;

   logic        o_start;
   logic        o_in_valid;
   logic        o_in_ready;
   logic        o_mem_wr_en;
   logic [15:0] o_mem_addr;
   logic [15:0] o_mem_wdata;
   logic        o_done;
   logic        o_err;
   logic [15:0] o_word_count;

   exp_t        sb[$];
   exp_t        ovf_q[$];
   exp_t        mon_e;
   logic [15:0] nxt_addr;
   logic [15:0] first_w;
   int          acc_cnt;
   int          n_chk;
   int          n_pass;

   always #5 clk = ~clk;

   instr_stream_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_imm(in_imm), .in_cond(in_cond),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .done(done), .err(err), .word_count(word_count)
   );

   instr_stream_encoder #(.ADDR_W(16), .BASE_ADDR(16'hFFFC), .FIFO_DEPTH(4)) u_ovf (
      .clk(clk), .rst_n(rst_n), .start(o_start),
      .in_valid(o_in_valid), .in_ready(o_in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_imm(in_imm), .in_cond(in_cond),
      .mem_wr_en(o_mem_wr_en), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata), .mem_ready(mem_ready),
      .done(o_done), .err(o_err), .word_count(o_word_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, a, b, c,
                                       input logic [8:0] imm, input logic [2:0] cond);
      case (op)
         4'hA, 4'hB: return {op, a, imm[7:0]};
         4'hC:       return {op, cond, imm};
         4'hD:       return {op, cond, 1'b0, b, 4'h0};
         4'hE:       return {op, a, 8'h00};
         4'hF:       return 16'hF000;
         default:    return {op, a, b, c};
      endcase
   endfunction

   // Offer one record from posedge+1 until accepted; record expectation at acceptance.
   task automatic send(input logic [3:0] op, a, b, c, input logic [8:0] imm,
                       input logic [2:0] cond, input logic [15:0] exp_w);
      bit ok;
      ok = 1'b0;
      in_op = op; in_a = a; in_b = b; in_c = c; in_imm = imm; in_cond = cond;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{addr: nxt_addr, dat: exp_w});
            nxt_addr = nxt_addr + 16'd2;
            acc_cnt++;
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_rnd();
      logic [3:0] op, a, b, c;
      logic [8:0] imm;
      logic [2:0] cond;
      op   = 4'($urandom_range(0, 14));
      a    = 4'($urandom);
      b    = 4'($urandom);
      c    = 4'($urandom);
      imm  = 9'($urandom);
      cond = 3'($urandom);
      send(op, a, b, c, imm, cond, enc(op, a, b, c, imm, cond));
   endtask

   task automatic wait_acc(input int n);
      int i;
      i = 0;
      while (acc_cnt < n && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (acc_cnt < n) chk("acc_timeout", acc_cnt, n);
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (sb.size() != 0 && i < 300) begin
         @(negedge clk);
         i++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   // Every completed write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && mem_wr_en && mem_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", mem_wr_en, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("wr_addr", mem_addr, mon_e.addr);
            chk("wr_data", mem_wdata, mon_e.dat);
         end
      end
   end

   // Collect writes from the overflow instance.
   always @(negedge clk) begin
      if (rst_n && o_mem_wr_en && mem_ready)
         ovf_q.push_back('{addr: o_mem_addr, dat: o_mem_wdata});
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk = 0; n_pass = 0; acc_cnt = 0; nxt_addr = 16'h0000;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      o_start = 1'b0; o_in_valid = 1'b0;
      in_op = '0; in_a = '0; in_b = '0; in_c = '0; in_imm = '0; in_cond = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_wr_en", mem_wr_en, 1'b0);
      chk("rst_wdata", mem_wdata, 16'h0000);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_count", word_count, 16'h0000);
      @(posedge clk); #1;

      // Encode sweep, unused fields filled with junk
      send(4'h0, 4'h1, 4'h2, 4'h3, 9'h155, 3'h7, 16'h0123);
      send(4'h4, 4'h4, 4'h5, 4'h7, 9'h0AA, 3'h1, 16'h4457);
      send(4'h8, 4'h3, 4'h2, 4'h4, 9'h1FF, 3'h2, 16'h8324);
      send(4'hA, 4'h2, 4'h7, 4'h5, 9'h1AB, 3'h6, 16'hA2AB);
      send(4'hC, 4'hF, 4'hE, 4'hD, 9'h1FF, 3'h3, 16'hC7FF);
      send(4'hD, 4'h9, 4'h6, 4'hB, 9'h123, 3'h5, 16'hDA60);
      send(4'hE, 4'h9, 4'h3, 4'h4, 9'h0FF, 3'h2, 16'hE900);
      send(4'hF, 4'h1, 4'h2, 4'h3, 9'h1FF, 3'h7, 16'hF000);
      wait_drain();
      @(negedge clk);
      chk("sweep_done", done, 1'b1);
      chk("sweep_count", word_count, 16'd8);
      chk("done_in_ready", in_ready, 1'b0);
      chk("done_wr_en", mem_wr_en, 1'b0);
      chk("sweep_err", err, 1'b0);

      // Restart from DONE
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nxt_addr = 16'h0000;
      @(negedge clk);
      chk("restart_addr", mem_addr, 16'h0000);
      chk("restart_count", word_count, 16'h0000);
      chk("restart_done", done, 1'b0);
      chk("restart_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Backpressure: six records offered while memory stalls
      mem_ready = 1'b0;
      acc_cnt = 0;
      fork
         for (int k = 0; k < 6; k++) send_rnd();
         begin
            wait_acc(4);
            first_w = sb[0].dat;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_in_ready", in_ready, 1'b0);
               chk("bp_wr_en", mem_wr_en, 1'b1);
               chk("bp_wdata_stable", mem_wdata, first_w);
            end
            chk("bp_accepted", acc_cnt, 4);
            @(posedge clk); #1 mem_ready = 1'b1;
         end
      join
      wait_drain();
      @(negedge clk);
      chk("bp_count", word_count, 16'd6);
      @(posedge clk); #1;

      // Full buffer streaming: push and pop every cycle
      mem_ready = 1'b0;
      acc_cnt = 0;
      fork
         for (int k = 0; k < 12; k++) send_rnd();
         begin
            wait_acc(4);
            @(posedge clk); #1 mem_ready = 1'b1;
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               chk("pp_in_ready", in_ready, 1'b1);
               chk("pp_wr_en", mem_wr_en, 1'b1);
            end
         end
      join
      wait_drain();
      @(negedge clk);
      chk("pp_count", word_count, 16'd18);
      @(posedge clk); #1;

      // Stop on HLT with the buffer not full
      mem_ready = 1'b0;
      send_rnd();
      send(4'hF, 4'h0, 4'h0, 4'h0, 9'h000, 3'h0, 16'hF000);
      in_op = 4'h1; in_a = 4'h5; in_b = 4'h6; in_c = 4'h7; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hlt_in_ready", in_ready, 1'b0);
         chk("hlt_not_done", done, 1'b0);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      mem_ready = 1'b1;
      wait_drain();
      @(negedge clk);
      chk("hlt_done", done, 1'b1);
      chk("hlt_count", word_count, 16'd20);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nxt_addr = 16'h0000;
      send_rnd();
      wait_drain();
      @(negedge clk);
      chk("restart2_count", word_count, 16'd1);
      chk("restart2_done", done, 1'b0);

      // start while loading has no effect
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("start_in_load_addr", mem_addr, 16'h0002);
      chk("start_in_load_count", word_count, 16'd1);
      @(posedge clk); #1;

      // Reset mid-stall with words queued
      mem_ready = 1'b0;
      send_rnd(); send_rnd(); send_rnd();
      @(negedge clk);
      chk("pre_rst_wr_en", mem_wr_en, 1'b1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      sb.delete();
      nxt_addr = 16'h0000;
      @(negedge clk);
      chk("mrst_wr_en", mem_wr_en, 1'b0);
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_addr", mem_addr, 16'h0000);
      chk("mrst_count", word_count, 16'h0000);
      chk("mrst_wdata", mem_wdata, 16'h0000);
      @(posedge clk); #1 mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("mrst_no_write", mem_wr_en, 1'b0);
      end
      @(posedge clk); #1;

      // Address overflow on the instance based at 0xFFFC
      ovf_q.delete();
      in_op = 4'h1; in_a = 4'h1; in_b = 4'h2; in_c = 4'h3; o_in_valid = 1'b1;
      @(negedge clk); chk("ovf_rdy0", o_in_ready, 1'b1);
      @(posedge clk); #1 in_op = 4'h2; in_a = 4'h4; in_b = 4'h5; in_c = 4'h6;
      @(negedge clk); chk("ovf_rdy1", o_in_ready, 1'b1);
      @(posedge clk); #1 in_op = 4'h3; in_a = 4'h7; in_b = 4'h8; in_c = 4'h9;
      @(negedge clk); chk("ovf_rdy2", o_in_ready, 1'b1);
      @(posedge clk); #1 o_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("ovf_writes", ovf_q.size(), 2);
      if (ovf_q.size() > 0) begin
         chk("ovf_addr0", ovf_q[0].addr, 16'hFFFC);
         chk("ovf_data0", ovf_q[0].dat, 16'h1123);
      end
      if (ovf_q.size() > 1) begin
         chk("ovf_addr1", ovf_q[1].addr, 16'hFFFE);
         chk("ovf_data1", ovf_q[1].dat, 16'h2456);
      end
      chk("ovf_err", o_err, 1'b1);
      chk("ovf_wr_en", o_mem_wr_en, 1'b0);
      chk("ovf_in_ready", o_in_ready, 1'b0);
      chk("ovf_count", o_word_count, 16'd2);
      chk("ovf_done", o_done, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
